// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the data cache.
// Provides the controller state enum and the fixed line geometry
// (4 words per line, 4 bytes per word).
package dcache_pkg;

    localparam int LINE_WORDS    = 4;
    localparam int WORD_OFF_BITS = 2;
    localparam int BYTE_OFF_BITS = 2;
    localparam int LINE_OFF_BITS = WORD_OFF_BITS + BYTE_OFF_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE
    } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: storage for the direct-mapped data cache.
// Ports:
//   clk, rst              clock; asynchronous active-high reset (valid bits only)
//   rd_index, rd_word     combinational lookup -> rd_valid, rd_tag, rd_data
//   wr_en/index/word/be   synchronous word write with byte-lane merge
//   wr_data
//   inst_en, inv_en       line install (tag + valid) / line invalidate strobes
//   ln_index, inst_tag    target line and tag for install/invalidate
// Tag and data storage are deliberately not reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int TAG_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(SETS)-1:0]   rd_index,
    input  logic [WORD_OFF_BITS-1:0]  rd_word,
    output logic                      rd_valid,
    output logic [TAG_W-1:0]          rd_tag,
    output logic [31:0]               rd_data,
    input  logic                      wr_en,
    input  logic [$clog2(SETS)-1:0]   wr_index,
    input  logic [WORD_OFF_BITS-1:0]  wr_word,
    input  logic [3:0]                wr_be,
    input  logic [31:0]               wr_data,
    input  logic                      inst_en,
    input  logic                      inv_en,
    input  logic [$clog2(SETS)-1:0]   ln_index,
    input  logic [TAG_W-1:0]          inst_tag
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][LINE_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index][rd_word];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inst_en) begin
            valid_q[ln_index] <= 1'b1;
        end else if (inv_en) begin
            valid_q[ln_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (inst_en) begin
            tag_mem[ln_index] <= inst_tag;
        end
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Load hits return data combinationally with no stall; load misses refill a
// 4-word line over the req/ack memory port; stores always write through.
// Optional build macro: DCACHE_STATS_EN adds hit_count / miss_count outputs.
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   cpu_req/we/be/addr/wdata          core load/store request
//   cpu_rdata, stall                  load word (0 unless idle load hit); core stall
//   mem_req/we/be/addr/wdata          memory request, held until mem_ack
//   mem_ack, mem_rdata                one-cycle completion pulse and read data
//   hit_count, miss_count             (DCACHE_STATS_EN only) load statistics
//
// state    | meaning
// S_IDLE   | serve load hits, detect misses and stores
// S_REFILL | fetch 4 words of the missed line, install on the last ack
// S_WRITE  | write the latched store through to memory
module data_cache
    import dcache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int LINE_W = ADDR_W - LINE_OFF_BITS;
    localparam int TAG_W  = LINE_W - IDX_W;

    dcache_state_t state_q, state_d;

    logic [1:0]                 cnt_q;
    logic [LINE_W-1:0]          line_q;
    logic [ADDR_W-1:BYTE_OFF_BITS] st_addr_q;
    logic [3:0]                 st_be_q;
    logic [31:0]                st_wdata_q;

    logic [LINE_W-1:0]          lk_line;
    logic [WORD_OFF_BITS-1:0]   lk_word;
    logic                       rd_valid;
    logic [TAG_W-1:0]           rd_tag;
    logic [31:0]                rd_data;
    logic                       hit_line;

    logic                       wr_en, inst_en, inv_en;
    logic [IDX_W-1:0]           wr_index, ln_index;
    logic [WORD_OFF_BITS-1:0]   wr_word;
    logic [3:0]                 wr_be;
    logic [31:0]                wr_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[BYTE_OFF_BITS-1:0];

    // In S_WRITE the lookup follows the latched store so the merge decision
    // does not depend on the core holding its inputs.
    assign lk_line  = (state_q == S_WRITE) ? st_addr_q[ADDR_W-1:LINE_OFF_BITS]
                                           : cpu_addr[ADDR_W-1:LINE_OFF_BITS];
    assign lk_word  = (state_q == S_WRITE) ? st_addr_q[LINE_OFF_BITS-1:BYTE_OFF_BITS]
                                           : cpu_addr[LINE_OFF_BITS-1:BYTE_OFF_BITS];
    assign hit_line = rd_valid && (rd_tag == lk_line[LINE_W-1:IDX_W]);

    dcache_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (lk_line[IDX_W-1:0]),
        .rd_word  (lk_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_word  (wr_word),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .inst_en  (inst_en),
        .inv_en   (inv_en),
        .ln_index (ln_index),
        .inst_tag (line_q[LINE_W-1:IDX_W])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            st_addr_q  <= '0;
            st_be_q    <= '0;
            st_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cpu_req) begin
                if (cpu_we) begin
                    st_addr_q  <= cpu_addr[ADDR_W-1:BYTE_OFF_BITS];
                    st_be_q    <= cpu_be;
                    st_wdata_q <= cpu_wdata;
                end else if (!hit_line) begin
                    line_q <= cpu_addr[ADDR_W-1:LINE_OFF_BITS];
                    cnt_q  <= '0;
                end
            end else if (state_q == S_REFILL && mem_ack) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_en     = 1'b0;
        wr_index  = lk_line[IDX_W-1:0];
        wr_word   = lk_word;
        wr_be     = '0;
        wr_data   = '0;
        inst_en   = 1'b0;
        inv_en    = 1'b0;
        ln_index  = lk_line[IDX_W-1:0];
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        stall   = 1'b1;
                        state_d = S_WRITE;
                    end else if (hit_line) begin
                        cpu_rdata = rd_data;
                    end else begin
                        // Drop the victim's valid bit now so a partially
                        // overwritten line can never be seen as a hit.
                        stall   = 1'b1;
                        inv_en  = 1'b1;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_be   = 4'hF;
                mem_addr = {line_q, cnt_q, 2'b00};
                wr_index = line_q[IDX_W-1:0];
                ln_index = line_q[IDX_W-1:0];
                wr_word  = cnt_q;
                wr_be    = 4'hF;
                wr_data  = mem_rdata;
                if (mem_ack) begin
                    wr_en = 1'b1;
                    if (cnt_q == 2'd3) begin
                        inst_en = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = st_be_q;
                mem_addr  = {st_addr_q, 2'b00};
                mem_wdata = st_wdata_q;
                stall     = !mem_ack;
                wr_be     = st_be_q;
                wr_data   = st_wdata_q;
                if (mem_ack) begin
                    wr_en   = hit_line;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == S_IDLE && cpu_req && !cpu_we) begin
            if (hit_line) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle core's load/store path (ALU result address, register write data) and the backing data memory. Load hits return data combinationally in the same cycle with no stall. Load misses refill a 4-word line over a req/ack memory port while stalling the core. Stores always write through to memory and update the cached word on a hit.

## Interface
Parameters:
- SETS, 16, number of lines; power of two, ≥2
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  load/store valid this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  4  store byte enables; ignored on loads
- cpu_addr  in  ADDR_W  byte address; bits[1:0] ignored
- cpu_wdata  in  32  store data, already lane-aligned
- cpu_rdata  out  32  full load word; sub-word extraction is done by the core
- stall  out  1  core must hold PC and all request inputs
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid with it
- mem_rdata  in  32  memory read data

## Operation
- Address split: [1:0] byte, [3:2] word in line, next log2(SETS) bits index, remaining bits tag.
- hit = cpu_req & valid[index] & (tag[index] == addr tag).
- States:
  - S_IDLE:
    - Load hit: cpu_rdata = line word, stall = 0.
    - Load miss: stall = 1; latch line base; go to S_REFILL with cnt = 0.
    - Store (hit or miss): stall = 1; latch addr/be/wdata; go to S_WRITE.
  - S_REFILL:
    - mem_req = 1, mem_we = 0, mem_be = 4'hF, mem_addr = base + 4·cnt.
    - Each mem_ack writes mem_rdata into word cnt, then cnt++.
    - On the 4th ack: set valid and tag, go to S_IDLE.
    - stall = 1 throughout.
  - S_WRITE:
    - mem_req = 1, mem_we = 1, latched addr/be/wdata driven.
    - On mem_ack: if the line is valid with a matching tag, merge the enabled bytes into the cached word.
    - On mem_ack: stall = 0 in that cycle (store commits), go to S_IDLE.
- mem_ack is ignored in S_IDLE.
- Store miss allocates nothing.
- When mem_req = 0, all mem_* outputs are 0.
- cpu_rdata = 0 unless it is an S_IDLE load hit.
- cpu_req dropping mid-refill: the refill still completes; the line is installed.

## Timing
- Reset, asynchronous, takes effect immediately:
  - State → S_IDLE, cnt → 0, all valid bits → 0.
  - mem_req/mem_we/mem_be/mem_addr/mem_wdata → 0.
  - Statistics counters → 0.
  - Data and tag arrays are not reset.
  - Reset during refill or write abandons the transaction; the line stays invalid.
- stall is combinational from state, hit, and cpu_req; it is 0 when cpu_req = 0 in S_IDLE.
- Load hit: 0 stall cycles.
- Load miss with zero-wait memory (ack every cycle): 5 stall cycles, i.e. 1 detect + 4 refill; the hit is served in the 6th cycle.
- Store with zero-wait memory: 1 stall cycle; commits in the S_WRITE ack cycle.
- Memory outputs change only on the clock edge after an ack; they are stable while mem_req is held.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds output ports hit_count (32) and miss_count (32).
  - hit_count increments on each load completing as an S_IDLE hit.
  - miss_count increments on each S_IDLE→S_REFILL transition.
  - Stores are not counted; both counters wrap modulo 2^32.
- DCACHE_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - dcache_state_t enum {S_IDLE, S_REFILL, S_WRITE}
  - LINE_WORDS = 4, WORD_OFF_BITS = 2, BYTE_OFF_BITS = 2
- Sub-module dcache_array:
  - valid bits (async reset), tag array, data array.
  - Combinational read; synchronous word write with byte-merge.
  - Line install (tag+valid) on a single strobe.
- FSM, counter, and address latches live in data_cache.

## Test plan
- Reset, then load 0x100 with zero-wait memory → 5 stall cycles; four mem_req reads at 0x100, 0x104, 0x108, 0x10C; cpu_rdata = mem[0x100]; an immediate reload of 0x104 hits with stall = 0.
- Store 0xDEADBEEF, be = 4'b0011, to cached 0x104 → one write at 0x104 with mem_be = 0011; a subsequent load hit returns the upper half old and the lower half 0xBEEF.
- Store miss to 0x200 then load 0x200 → write first; the load misses (no allocate) and refills from 0x200.
- Conflict: load 0x100, then load 0x100 + 64·SETS/4 (same index, other tag) → second load misses and evicts; reloading 0x100 misses again.
- Assert rst after the 2nd refill ack with ack delayed 3 cycles → mem_req drops immediately; the next load to the same line misses and refills fully.
- With DCACHE_STATS_EN: sequence of 3 hits, 2 misses, 1 store → hit_count = 3, miss_count = 2.
